// File: rtl/ahb_apb_bridge_n_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM states, HTRANS/HRESP codes
// and the slave-index width.
package bridge_pkg;

   localparam int unsigned IDX_W = 3;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_e;

   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_apb_bridge_n_if.sv
// AHB slave side plus muxed APB master side of the bridge in one bundle.
// slave = bridge view, master = surrounding bus / bench view.
interface ahb_apb_bridge_n_if #(
   parameter int DATA_W = 32,
   parameter int NSLV   = 4
);
   logic              hreadyin;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [31:0]       haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hreadyout;
   logic [1:0]        hresp;
   logic [DATA_W-1:0] hrdata;
   logic [NSLV-1:0]   psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport slave (
      input  hreadyin, htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
      output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );

   modport master (
      output hreadyin, htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
      input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/ahb_apb_bridge_n_decode.sv
// Combinational address decode: slave index = (haddr-BASE)>>REGION_LOG2,
// error when below BASE or past the last slave region.
module ahb_apb_decode
   import bridge_pkg::*;
#(
   parameter int          NSLV        = 4,
   parameter logic [31:0] BASE        = 32'h8000_0000,
   parameter int          REGION_LOG2 = 28
) (
   input  logic [31:0]      haddr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             err_o
);
   logic [31:0] offset;
   logic [31:0] region;

   always_comb begin
      offset = haddr_i - BASE;
      region = offset >> REGION_LOG2;
      idx_o  = region[IDX_W-1:0];
      err_o  = (haddr_i < BASE) || (region >= 32'(NSLV));
   end
endmodule

// File: rtl/ahb_apb_bridge_n.sv
// AHB-to-APB bridge with NSLV one-hot selects and a two-cycle ERROR response.
// Define BRIDGE_TIMEOUT_EN to abort APB accesses that hold PREADY low for TIMEOUT cycles.
module ahb_apb_bridge_n
   import bridge_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          NSLV        = 4,
   parameter logic [31:0] BASE        = 32'h8000_0000,
   parameter int          REGION_LOG2 = 28,
   parameter int          TIMEOUT     = 16
) (
   input logic              hclk,
   input logic              hresetn,
   ahb_apb_bridge_n_if.slave bus
);
   state_e            state_q;
   logic [NSLV-1:0]   psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [31:0]       paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [DATA_W-1:0] hrdata_q;
   logic [IDX_W-1:0]  idx_q;

   logic [IDX_W-1:0]  dec_idx;
   logic              dec_err;
   logic              done_ok;
   logic              hready;
   logic              valid;
   state_e            accept_st;
   logic [NSLV-1:0]   accept_psel;

`ifdef BRIDGE_TIMEOUT_EN
   logic [7:0]        tcnt_q;
`else
   logic              unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   function automatic logic [NSLV-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NSLV-1:0] r;
      for (int unsigned i = 0; i < NSLV; i++) begin
         r[i] = (idx == IDX_W'(i));
      end
      return r;
   endfunction

   ahb_apb_decode #(
      .NSLV        (NSLV),
      .BASE        (BASE),
      .REGION_LOG2 (REGION_LOG2)
   ) u_decode (
      .haddr_i (bus.haddr),
      .idx_o   (dec_idx),
      .err_o   (dec_err)
   );

   // Completion is combinational on PREADY so a new transfer can be taken on the
   // same edge; reads jump straight to SETUP, so their select is precomputed.
   always_comb begin
      done_ok     = (state_q == ST_ACCESS) && bus.pready && !bus.pslverr;
      hready      = (state_q == ST_IDLE) || (state_q == ST_ERR2) || done_ok;
      valid       = bus.hreadyin && is_active(bus.htrans) && hready;
      accept_psel = '0;
      if (dec_err) begin
         accept_st = ST_ERR1;
      end else if (bus.hwrite) begin
         accept_st = ST_WWAIT;
      end else begin
         accept_st   = ST_SETUP;
         accept_psel = onehot(dec_idx);
      end
   end

   assign bus.hreadyout = hready;
   assign bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign bus.hrdata    = ((state_q == ST_ACCESS) && !pwrite_q) ? bus.prdata : hrdata_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= ST_IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         hrdata_q  <= '0;
         idx_q     <= '0;
`ifdef BRIDGE_TIMEOUT_EN
         tcnt_q    <= '0;
`endif
      end else begin
         if (valid) begin
            paddr_q  <= bus.haddr;
            pwrite_q <= bus.hwrite;
            idx_q    <= dec_idx;
         end
         unique case (state_q)
            ST_IDLE, ST_ERR2: begin
               state_q <= valid ? accept_st : ST_IDLE;
               psel_q  <= valid ? accept_psel : '0;
            end
            ST_WWAIT: begin
               pwdata_q <= bus.hwdata;
               psel_q   <= onehot(idx_q);
               state_q  <= ST_SETUP;
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.pready) begin
                  penable_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                  tcnt_q    <= '0;
`endif
                  if (bus.pslverr) begin
                     psel_q  <= '0;
                     state_q <= ST_ERR1;
                  end else begin
                     if (!pwrite_q) begin
                        hrdata_q <= bus.prdata;
                     end
                     state_q <= valid ? accept_st : ST_IDLE;
                     psel_q  <= valid ? accept_psel : '0;
                  end
               end
`ifdef BRIDGE_TIMEOUT_EN
               else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  tcnt_q    <= '0;
                  state_q   <= ST_ERR1;
               end else begin
                  tcnt_q <= tcnt_q + 8'd1;
               end
`endif
            end
            ST_ERR1: state_q <= ST_ERR2;
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_apb_bridge_n.sv
// Scoreboard bench for ahb_apb_bridge_n: directed AHB sequences, a scripted APB
// slave, and monitors that pop expected AHB responses and APB setups.
module tb_ahb_apb_bridge_n;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [1:0]  trans;
   } xfer_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        chk_rdata;
      int          lat;
   } ahb_exp_t;

   typedef struct {
      logic [3:0]  psel;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          acc;
      int          gap;
   } apb_exp_t;

   logic hclk;
   logic hresetn;

   ahb_apb_bridge_n_if #(.DATA_W(32), .NSLV(4)) bus ();

   ahb_apb_bridge_n #(
      .DATA_W      (32),
      .NSLV        (4),
      .BASE        (32'h8000_0000),
      .REGION_LOG2 (28),
      .TIMEOUT     (16)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   assign bus.hreadyin = bus.hreadyout;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   int checks = 0;
   int errors = 0;

   xfer_t    seq[$];
   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];

   int          cfg_waits = 0;
   logic        cfg_err   = 1'b0;
   logic [31:0] cfg_rdata = '0;
   logic        in_acc    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // APB slave model plus AHB/APB monitors; sampling happens at negedge+1.
   initial begin : monitor
      int          wcnt;
      int          cyc;
      int          dp_cyc;
      logic        dp_active;
      logic        prev_err_low;
      int          acc_cyc;
      int          last_end;
      logic        stable;
      apb_exp_t    cur;
      ahb_exp_t    e;
      logic [3:0]  s_psel;
      logic [31:0] s_addr;
      logic        s_wr;
      logic [31:0] s_wdata;

      wcnt = 0; cyc = 0; dp_cyc = 0; dp_active = 1'b0; prev_err_low = 1'b0;
      acc_cyc = 0; last_end = -100; stable = 1'b1;
      s_psel = '0; s_addr = '0; s_wr = 1'b0; s_wdata = '0;
      cur = '{psel: '0, addr: '0, wr: 1'b0, wdata: '0, acc: 0, gap: -1};
      bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
      forever begin
         @(negedge hclk);
         if (bus.penable) begin
            bus.pready  = (wcnt >= cfg_waits);
            bus.pslverr = bus.pready & cfg_err;
            bus.prdata  = cfg_rdata;
            wcnt++;
         end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            wcnt        = 0;
         end
         #1;
         cyc++;
         if (!hresetn) begin
            dp_active    = 1'b0;
            in_acc       = 1'b0;
            prev_err_low = 1'b0;
            continue;
         end

         if (dp_active) begin
            dp_cyc++;
            if (bus.hreadyout) begin
               if (ahb_q.size() == 0) begin
                  chk("ahb_unexpected_completion", 32'(dp_cyc), 32'hFFFF_FFFF);
               end else begin
                  e = ahb_q.pop_front();
                  chk("ahb_hresp", 32'(bus.hresp), 32'(e.resp));
                  chk("ahb_latency", 32'(dp_cyc), 32'(e.lat));
                  if (e.chk_rdata) chk("ahb_hrdata", bus.hrdata, e.rdata);
                  if (e.resp == 2'b01) chk("ahb_err_first_cycle", 32'(prev_err_low), 32'd1);
               end
               dp_active = 1'b0;
            end
         end
         if (bus.hreadyout && bus.hreadyin && bus.htrans[1]) begin
            dp_active = 1'b1;
            dp_cyc    = 0;
         end
         prev_err_low = !bus.hreadyout && (bus.hresp == 2'b01);

         if ((bus.psel != '0) && !bus.penable) begin
            if (apb_q.size() == 0) begin
               chk("apb_unexpected_setup", 32'(bus.psel), 32'd0);
            end else begin
               cur = apb_q.pop_front();
               chk("apb_setup_psel", 32'(bus.psel), 32'(cur.psel));
               chk("apb_setup_paddr", bus.paddr, cur.addr);
               chk("apb_setup_pwrite", 32'(bus.pwrite), 32'(cur.wr));
               if (cur.wr) chk("apb_setup_pwdata", bus.pwdata, cur.wdata);
               if (cur.gap >= 0) chk("apb_setup_gap", 32'(cyc - last_end), 32'(cur.gap));
               s_psel = bus.psel; s_addr = bus.paddr; s_wr = bus.pwrite; s_wdata = bus.pwdata;
               in_acc = 1'b1; acc_cyc = 0; stable = 1'b1;
            end
         end else if (bus.penable) begin
            if (!in_acc) chk("apb_penable_without_setup", 32'd1, 32'd0);
            acc_cyc++;
            if ((bus.psel !== s_psel) || (bus.paddr !== s_addr) ||
                (bus.pwrite !== s_wr) || (bus.pwdata !== s_wdata)) stable = 1'b0;
            if (bus.pready && in_acc) begin
               chk("apb_access_cycles", 32'(acc_cyc), 32'(cur.acc));
               chk("apb_signals_stable", 32'(stable), 32'd1);
               in_acc   = 1'b0;
               last_end = cyc;
            end
         end else if (in_acc) begin
            chk("apb_aborted_access_cycles", 32'(acc_cyc), 32'(cur.acc));
            chk("apb_signals_stable", 32'(stable), 32'd1);
            in_acc   = 1'b0;
            last_end = cyc;
         end
      end
   end

   task automatic add_x(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [1:0] t);
      xfer_t x;
      x.addr = a; x.wr = w; x.wdata = d; x.trans = t;
      seq.push_back(x);
   endtask

   task automatic add_ahb(input logic [1:0] r, input logic [31:0] d, input logic c, input int lat);
      ahb_exp_t x;
      x.resp = r; x.rdata = d; x.chk_rdata = c; x.lat = lat;
      ahb_q.push_back(x);
   endtask

   task automatic add_apb(input logic [3:0] s, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input int acc, input int gap);
      apb_exp_t x;
      x.psel = s; x.addr = a; x.wr = w; x.wdata = d; x.acc = acc; x.gap = gap;
      apb_q.push_back(x);
   endtask

   // Pipelined AHB master: address i+1 is held until the edge that ends data i.
   task automatic run_seq(input string name);
      int   n;
      int   guard;
      logic rdy;
      n = seq.size();
      @(posedge hclk); #1;
      for (int i = 0; i < n; i++) begin
         bus.htrans = seq[i].trans;
         bus.haddr  = seq[i].addr;
         bus.hwrite = seq[i].wr;
         rdy = 1'b0;
         for (guard = 0; guard < 200 && !rdy; guard++) begin
            @(negedge hclk); #2;
            rdy = bus.hreadyout;
            @(posedge hclk); #1;
         end
         chk({name, "_addr_accept"}, 32'(rdy), 32'd1);
         bus.hwdata = seq[i].wdata;
      end
      bus.htrans = 2'b00;
      seq.delete();
      guard = 0;
      while ((ahb_q.size() != 0 || apb_q.size() != 0 || in_acc) && guard < 400) begin
         @(negedge hclk); #2;
         guard++;
      end
      chk({name, "_drain"}, 32'(guard < 400), 32'd1);
      @(negedge hclk); #2;
      chk({name, "_idle_after"}, {24'd0, bus.hreadyout, bus.hresp, bus.psel, bus.penable},
          {24'd0, 1'b1, 2'b00, 4'b0000, 1'b0});
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int guard;
      bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0;
      hresetn = 1'b1;
      #1 hresetn = 1'b0;
      #2;
      chk("reset_hready_hresp", {29'd0, bus.hreadyout, bus.hresp}, {29'd0, 1'b1, 2'b00});
      chk("reset_psel_penable_pwrite", {26'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
      chk("reset_paddr", bus.paddr, 32'd0);
      chk("reset_pwdata", bus.pwdata, 32'd0);
      chk("reset_hrdata", bus.hrdata, 32'd0);
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;

      // BUSY with a decodable address must not start anything
      @(posedge hclk); #1;
      bus.htrans = 2'b01; bus.haddr = 32'h8000_0000; bus.hwrite = 1'b0;
      repeat (3) @(posedge hclk);
      #1 bus.htrans = 2'b00;
      @(negedge hclk); #2;
      chk("busy_ignored", {27'd0, bus.hreadyout, bus.psel}, {27'd0, 1'b1, 4'b0000});

      cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'hA5A5_5A5A;
      add_x(32'h8000_0010, 1'b0, 32'h0, 2'b10);
      add_ahb(2'b00, 32'hA5A5_5A5A, 1'b1, 2);
      add_apb(4'b0001, 32'h8000_0010, 1'b0, 32'h0, 1, -1);
      run_seq("read_s0");

      cfg_waits = 3;
      add_x(32'h9000_0004, 1'b1, 32'h1234_5678, 2'b10);
      add_ahb(2'b00, 32'h0, 1'b0, 6);
      add_apb(4'b0010, 32'h9000_0004, 1'b1, 32'h1234_5678, 4, -1);
      run_seq("write_s1_wait3");

      cfg_waits = 0;
      add_x(32'hC000_0000, 1'b0, 32'h0, 2'b10);
      add_ahb(2'b01, 32'h0, 1'b0, 2);
      run_seq("decode_err_high");

      cfg_err = 1'b1;
      add_x(32'h8000_0020, 1'b1, 32'hDEAD_BEEF, 2'b10);
      add_ahb(2'b01, 32'h0, 1'b0, 5);
      add_apb(4'b0001, 32'h8000_0020, 1'b1, 32'hDEAD_BEEF, 1, -1);
      run_seq("write_pslverr");

      cfg_err = 1'b0; cfg_rdata = 32'h0BAD_F00D;
      add_x(32'hA000_0000, 1'b0, 32'h0, 2'b10);
      add_x(32'hA000_0004, 1'b0, 32'h0, 2'b11);
      add_ahb(2'b00, 32'h0BAD_F00D, 1'b1, 2);
      add_ahb(2'b00, 32'h0BAD_F00D, 1'b1, 2);
      add_apb(4'b0100, 32'hA000_0000, 1'b0, 32'h0, 1, -1);
      add_apb(4'b0100, 32'hA000_0004, 1'b0, 32'h0, 1, 1);
      run_seq("b2b_read");

      cfg_waits = 1;
      add_x(32'hBFFF_FFFC, 1'b1, 32'hCAFE_F00D, 2'b10);
      add_ahb(2'b00, 32'h0, 1'b0, 4);
      add_apb(4'b1000, 32'hBFFF_FFFC, 1'b1, 32'hCAFE_F00D, 2, -1);
      run_seq("write_last_slave");

      cfg_waits = 0; cfg_rdata = 32'h1357_9BDF;
      add_x(32'h7FFF_FFFC, 1'b0, 32'h0, 2'b10);
      add_x(32'h8000_0008, 1'b0, 32'h0, 2'b10);
      add_ahb(2'b01, 32'h0, 1'b0, 2);
      add_ahb(2'b00, 32'h1357_9BDF, 1'b1, 2);
      add_apb(4'b0001, 32'h8000_0008, 1'b0, 32'h0, 1, -1);
      run_seq("below_base_then_read");

`ifdef BRIDGE_TIMEOUT_EN
      cfg_waits = 1000;
      add_x(32'h8000_0004, 1'b0, 32'h0, 2'b10);
      add_ahb(2'b01, 32'h0, 1'b0, 19);
      add_apb(4'b0001, 32'h8000_0004, 1'b0, 32'h0, 16, -1);
      run_seq("pready_timeout");
`endif

      // Reset in the middle of a stalled access
      cfg_waits = 1000;
      add_apb(4'b0001, 32'h8000_0000, 1'b0, 32'h0, 0, -1);
      @(posedge hclk); #1;
      bus.htrans = 2'b10; bus.haddr = 32'h8000_0000; bus.hwrite = 1'b0;
      @(posedge hclk); #1;
      bus.htrans = 2'b00;
      guard = 0;
      while (!bus.penable && guard < 20) begin
         @(negedge hclk); #2;
         guard++;
      end
      chk("rst_mid_reached_access", 32'(bus.penable), 32'd1);
      repeat (2) @(negedge hclk);
      #2;
      chk("rst_mid_pre", {27'd0, bus.hreadyout, bus.psel}, {27'd0, 1'b0, 4'b0001});
      hresetn = 1'b0;
      #1;
      chk("rst_mid_async", {24'd0, bus.psel, bus.penable, bus.hreadyout, bus.hresp},
          {24'd0, 4'b0000, 1'b0, 1'b1, 2'b00});
      repeat (2) @(negedge hclk);
      #2;
      hresetn = 1'b1;
      ahb_q.delete();
      apb_q.delete();
      cfg_waits = 0;

      cfg_rdata = 32'h2468_ACE0;
      add_x(32'h9000_0100, 1'b0, 32'h0, 2'b10);
      add_ahb(2'b00, 32'h2468_ACE0, 1'b1, 2);
      add_apb(4'b0010, 32'h9000_0100, 1'b0, 32'h0, 1, -1);
      run_seq("read_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge_n.md
AHB_APB_BRIDGE_N -- requirements
Module: ahb_apb_bridge_n

Interface
REQ-001 SHALL have parameter DATA_W, default 32: AHB/APB data width (32 or 64).
REQ-002 SHALL have parameter NSLV, default 4: number of APB slaves (1..8).
REQ-003 SHALL have parameter BASE, default 32'h8000_0000: start of the bridge address window.
REQ-004 SHALL have parameter REGION_LOG2, default 28: log2 of the bytes per slave region.
REQ-005 SHALL have parameter TIMEOUT, default 16: PREADY timeout limit in cycles (2..255).
REQ-006 SHALL have the following ports, clock and reset first:
- hclk  in  1  sole clock; all state changes on its rising edge.
- hresetn  in  1  reset; asynchronous, active-low.
- hreadyin  in  1  AHB HREADY from the bus.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  AHB write flag.
- haddr  in  32  AHB address.
- hwdata  in  DATA_W  AHB write data.
- hreadyout  out  1  bridge ready.
- hresp  out  2  AHB response, OKAY=00, ERROR=01.
- hrdata  out  DATA_W  AHB read data.
- psel  out  NSLV  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  32  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  muxed APB read data.
- pready  in  1  muxed APB ready.
- pslverr  in  1  muxed APB error.

Function
REQ-007 SHALL treat a transfer as valid when hreadyin=1, htrans is NONSEQ(10) or SEQ(11), and hreadyout=1; IDLE(00) and BUSY(01) SHALL be ignored.
REQ-008 SHALL register haddr, hwrite and the decoded slave index on the edge where a valid transfer is sampled.
REQ-009 SHALL decode the slave index as (haddr-BASE)>>REGION_LOG2; an index >= NSLV, or haddr < BASE, SHALL be a decode error.
REQ-010 SHALL implement the FSM states IDLE, WWAIT, SETUP, ACCESS, ERR1 and ERR2.
REQ-011 SHALL make these transitions on a valid transfer from IDLE: decode error -> ERR1; write -> WWAIT; read -> SETUP.
REQ-012 SHALL make these transitions: WWAIT -> SETUP, capturing hwdata into pwdata; SETUP -> ACCESS.
REQ-013 SHALL, in SETUP, assert psel[idx]=1 with penable=0; paddr, pwrite and pwdata SHALL be stable from SETUP through the end of ACCESS.
REQ-014 SHALL, in ACCESS, assert penable=1 and stay in ACCESS while pready=0.
REQ-015 SHALL complete the transfer on pready=1 with pslverr=0: hreadyout=1 and hresp=OKAY combinationally, and hrdata=prdata for reads.
REQ-016 SHALL, on pready=1 with pslverr=1, go to ERR1.
REQ-017 SHALL drive hreadyout=0 and hresp=ERROR in ERR1, then go to ERR2, where hreadyout=1 and hresp=ERROR, then go to IDLE.
REQ-018 SHALL drive hreadyout=0 in WWAIT, SETUP, ACCESS-before-pready and ERR1, and hreadyout=1 in IDLE.
REQ-019 SHALL, when a valid transfer is sampled on the ACCESS-completion edge, follow REQ-011 for it directly and SHALL NOT pass through IDLE.
REQ-020 SHALL, when a valid transfer is sampled in ERR2, accept it and follow REQ-011 for it.
REQ-021 SHALL meet these latencies from the address-phase edge to hreadyout=1 with zero APB wait states: read 2 cycles, write 3 cycles, decode error 2 cycles.
REQ-022 SHALL deassert psel and penable in IDLE, WWAIT, ERR1 and ERR2, and SHALL NOT issue an APB access for a decode error.

Reset
REQ-023 SHALL, on hresetn=0, immediately and asynchronously force: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=OKAY, timeout counter=0.
REQ-024 SHALL abandon any APB access in progress at reset without a completion response.

Configuration
REQ-025 SHALL, with BRIDGE_TIMEOUT_EN defined, count ACCESS cycles with pready=0 in an 8-bit counter that clears on leaving ACCESS.
REQ-026 SHALL, with BRIDGE_TIMEOUT_EN defined, abort when the count reaches TIMEOUT: psel=0, penable=0, next state ERR1.
REQ-027 SHALL, without BRIDGE_TIMEOUT_EN, include no counter and wait for pready indefinitely.

Structure
REQ-028 SHALL take the FSM state enum, HTRANS codes and HRESP codes from the shared package bridge_pkg.
REQ-029 SHALL place the address decode (index plus error flag) in a combinational sub-module named ahb_apb_decode.

Verification
REQ-030 SHALL cover: read of 0x8000_0010 with pready=1 and prdata=0xA5A5_5A5A -> psel=0001 in SETUP, hrdata=0xA5A5_5A5A, hreadyout high 2 cycles after the address phase.
REQ-031 SHALL cover: write of 0x9000_0004 with hwdata=0x1234_5678 and pready held low 3 cycles -> psel=0010, pwdata=0x1234_5678 stable, ACCESS lasts 4 cycles.
REQ-032 SHALL cover: read of 0xC000_0000 with NSLV=4 -> no psel activity; ERR1 then ERR2 with hresp=01 and hreadyout 0 then 1.
REQ-033 SHALL cover: pslverr=1 on completion of a write -> two-cycle ERROR response, then IDLE.
REQ-034 SHALL cover: back-to-back NONSEQ read then SEQ read -> second SETUP in the cycle after the first ACCESS completes.
REQ-035 SHALL cover, with BRIDGE_TIMEOUT_EN and TIMEOUT=16: pready stuck at 0 -> abort after 16 ACCESS cycles with an ERROR response; hresetn pulsed low mid-ACCESS -> psel=0 and hreadyout=1 immediately.
